sm3_msg_expnd: RTL

SM3 message-expansion engine, the producer side of the compression-round datapath. Accepts one 512-bit message block as sixteen 32-bit words over a ready/valid input, then streams the 64 per-round operand sets (W_j, W'_j, rotated T_j, round-type flag) to the compression round logic under a second ready/valid handshake. It uses a 16-word sliding window that shifts once per consumed round, so there is no 68-word array.

---
 rtl/sm3_msg_expnd.sv | 111 +++++++++++
 1 files changed

// File: rtl/sm3_msg_expnd.sv
// SM3 message expansion: loads one 16-word block, then streams the 64 round operand
// sets (W_j, W'_j, rotated T_j) through a 16-word sliding window.
module sm3_msg_expnd #(
  parameter int WORD_DW   = 32,
  parameter int BLK_WORDS = 16,
  parameter int RND_NUM   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               msg_valid_i,
  input  logic [WORD_DW-1:0] msg_word_i,
  output logic               msg_ready_o,
  output logic               wj_valid_o,
  input  logic               wj_ready_i,
  output logic [WORD_DW-1:0] wj_o,
  output logic [WORD_DW-1:0] wjj_o,
  output logic [WORD_DW-1:0] tj_o,
  output logic               round_sm_16_o,
  output logic [5:0]         round_o,
  output logic               blk_done_o
);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  localparam logic [WORD_DW-1:0] T_LO      = 32'h79CC4519;
  localparam logic [WORD_DW-1:0] T_HI      = 32'h7A879D8A;
  localparam logic [3:0]         LAST_WORD = 4'(BLK_WORDS - 1);
  localparam logic [5:0]         LAST_RND  = 6'(RND_NUM - 1);

  state_t             state;
  logic [3:0]         word_cnt;
  logic [5:0]         round;
  logic [WORD_DW-1:0] w [BLK_WORDS];
  logic [WORD_DW-1:0] w_new;
  logic               run;
  logic               last_rnd;

  function automatic logic [WORD_DW-1:0] rol_var(input logic [WORD_DW-1:0] x,
                                                 input logic [4:0] n);
    logic [2*WORD_DW-1:0] tmp;
    tmp = {x, x} << n;
    return tmp[2*WORD_DW-1:WORD_DW];
  endfunction

  function automatic logic [WORD_DW-1:0] p1(input logic [WORD_DW-1:0] x);
    return x ^ {x[16:0], x[31:17]} ^ {x[8:0], x[31:9]};
  endfunction

  assign run      = (state == ST_RUN);
  assign last_rnd = (round == LAST_RND);

  // Next window word: W_(j+16) from W_j, W_(j+3), W_(j+7), W_(j+10), W_(j+13)
  assign w_new = p1(w[0] ^ w[7] ^ {w[13][16:0], w[13][31:17]})
               ^ {w[3][24:0], w[3][31:25]} ^ w[10];

  assign msg_ready_o   = ~run;
  assign wj_valid_o    = run;
  assign wj_o          = w[0];
  assign wjj_o         = w[0] ^ w[4];
  assign round_o       = round;
  assign round_sm_16_o = run & (round[5:4] == 2'b00);
  assign blk_done_o    = run & last_rnd & wj_ready_i;
  assign tj_o          = !run                  ? '0 :
                         (round[5:4] == 2'b00) ? rol_var(T_LO, round[4:0]) :
                                                 rol_var(T_HI, round[4:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOAD;
      word_cnt <= '0;
      round    <= '0;
      for (int k = 0; k < BLK_WORDS; k++) w[k] <= '0;
    end else if (clr_i) begin
      state    <= ST_LOAD;
      word_cnt <= '0;
      round    <= '0;
      for (int k = 0; k < BLK_WORDS; k++) w[k] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (msg_valid_i) begin
            for (int k = 0; k < BLK_WORDS - 1; k++) w[k] <= w[k+1];
            w[BLK_WORDS-1] <= msg_word_i;
            word_cnt       <= word_cnt + 4'd1;
            if (word_cnt == LAST_WORD) begin
              state <= ST_RUN;
              round <= '0;
            end
          end
        end
        ST_RUN: begin
          if (wj_ready_i) begin
            for (int k = 0; k < BLK_WORDS - 1; k++) w[k] <= w[k+1];
            w[BLK_WORDS-1] <= w_new;
            // Window is left stale after the last round; the next load overwrites it
            if (last_rnd) begin
              state    <= ST_LOAD;
              round    <= '0;
              word_cnt <= '0;
            end else begin
              round <= round + 6'd1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
